// File: rtl/axi_mem_arb2.sv
// Two-master AXI4 arbiter in front of a single memory slave.
// Read and write paths each run an independent round-robin, transaction-locked FSM.
module axi_mem_arb2 #(
    parameter int AW = 32,
    parameter int DW = 128,
    parameter int IW = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            M0_ARVALID,
    output logic            M0_ARREADY,
    input  logic [IW-1:0]   M0_ARID,
    input  logic [AW-1:0]   M0_ARADDR,
    input  logic [7:0]      M0_ARLEN,
    input  logic [2:0]      M0_ARSIZE,
    input  logic [1:0]      M0_ARBURST,
    output logic            M0_RVALID,
    input  logic            M0_RREADY,
    output logic [IW-1:0]   M0_RID,
    output logic [DW-1:0]   M0_RDATA,
    output logic [1:0]      M0_RRESP,
    output logic            M0_RLAST,
    input  logic            M0_AWVALID,
    output logic            M0_AWREADY,
    input  logic [IW-1:0]   M0_AWID,
    input  logic [AW-1:0]   M0_AWADDR,
    input  logic [7:0]      M0_AWLEN,
    input  logic [2:0]      M0_AWSIZE,
    input  logic [1:0]      M0_AWBURST,
    input  logic            M0_WVALID,
    output logic            M0_WREADY,
    input  logic [DW-1:0]   M0_WDATA,
    input  logic [DW/8-1:0] M0_WSTRB,
    input  logic            M0_WLAST,
    output logic            M0_BVALID,
    input  logic            M0_BREADY,
    output logic [IW-1:0]   M0_BID,
    output logic [1:0]      M0_BRESP,
    input  logic            M1_ARVALID,
    output logic            M1_ARREADY,
    input  logic [IW-1:0]   M1_ARID,
    input  logic [AW-1:0]   M1_ARADDR,
    input  logic [7:0]      M1_ARLEN,
    input  logic [2:0]      M1_ARSIZE,
    input  logic [1:0]      M1_ARBURST,
    output logic            M1_RVALID,
    input  logic            M1_RREADY,
    output logic [IW-1:0]   M1_RID,
    output logic [DW-1:0]   M1_RDATA,
    output logic [1:0]      M1_RRESP,
    output logic            M1_RLAST,
    input  logic            M1_AWVALID,
    output logic            M1_AWREADY,
    input  logic [IW-1:0]   M1_AWID,
    input  logic [AW-1:0]   M1_AWADDR,
    input  logic [7:0]      M1_AWLEN,
    input  logic [2:0]      M1_AWSIZE,
    input  logic [1:0]      M1_AWBURST,
    input  logic            M1_WVALID,
    output logic            M1_WREADY,
    input  logic [DW-1:0]   M1_WDATA,
    input  logic [DW/8-1:0] M1_WSTRB,
    input  logic            M1_WLAST,
    output logic            M1_BVALID,
    input  logic            M1_BREADY,
    output logic [IW-1:0]   M1_BID,
    output logic [1:0]      M1_BRESP,
    output logic            S_ARVALID,
    input  logic            S_ARREADY,
    output logic [IW-1:0]   S_ARID,
    output logic [AW-1:0]   S_ARADDR,
    output logic [7:0]      S_ARLEN,
    output logic [2:0]      S_ARSIZE,
    output logic [1:0]      S_ARBURST,
    input  logic            S_RVALID,
    output logic            S_RREADY,
    input  logic [IW-1:0]   S_RID,
    input  logic [DW-1:0]   S_RDATA,
    input  logic [1:0]      S_RRESP,
    input  logic            S_RLAST,
    output logic            S_AWVALID,
    input  logic            S_AWREADY,
    output logic [IW-1:0]   S_AWID,
    output logic [AW-1:0]   S_AWADDR,
    output logic [7:0]      S_AWLEN,
    output logic [2:0]      S_AWSIZE,
    output logic [1:0]      S_AWBURST,
    output logic            S_WVALID,
    input  logic            S_WREADY,
    output logic [DW-1:0]   S_WDATA,
    output logic [DW/8-1:0] S_WSTRB,
    output logic            S_WLAST,
    input  logic            S_BVALID,
    output logic            S_BREADY,
    input  logic [IW-1:0]   S_BID,
    input  logic [1:0]      S_BRESP,
    output logic [1:0]      RD_GNT,
    output logic [1:0]      WR_GNT
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rdState_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wrState_e;

    rdState_e rdState_q, rdState_d;
    wrState_e wrState_q, wrState_d;
    logic     rdSel_q, rdSel_d, rdLast_q, rdLast_d;
    logic     wrSel_q, wrSel_d, wrLast_q, wrLast_d;

    // Round-robin pick: a lone requester wins; on contention the master not served last wins.
    function automatic logic pickMaster(input logic v0, input logic v1, input logic last);
        return (v0 && v1) ? ~last : v1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdState_q <= R_IDLE;
            wrState_q <= W_IDLE;
            rdSel_q   <= 1'b0;
            wrSel_q   <= 1'b0;
            rdLast_q  <= 1'b1;
            wrLast_q  <= 1'b1;
        end else begin
            rdState_q <= rdState_d;
            wrState_q <= wrState_d;
            rdSel_q   <= rdSel_d;
            wrSel_q   <= wrSel_d;
            rdLast_q  <= rdLast_d;
            wrLast_q  <= wrLast_d;
        end
    end

    always_comb begin
        rdState_d = rdState_q;
        rdSel_d   = rdSel_q;
        rdLast_d  = rdLast_q;
        case (rdState_q)
            R_IDLE: if (M0_ARVALID || M1_ARVALID) begin
                rdSel_d   = pickMaster(M0_ARVALID, M1_ARVALID, rdLast_q);
                rdState_d = R_ADDR;
            end
            R_ADDR: if (S_ARVALID && S_ARREADY) rdState_d = R_DATA;
            R_DATA: if (S_RVALID && S_RREADY && S_RLAST) begin
                rdState_d = R_IDLE;
                rdLast_d  = rdSel_q;
            end
            default: rdState_d = R_IDLE;
        endcase
    end

    always_comb begin
        wrState_d = wrState_q;
        wrSel_d   = wrSel_q;
        wrLast_d  = wrLast_q;
        case (wrState_q)
            W_IDLE: if (M0_AWVALID || M1_AWVALID) begin
                wrSel_d   = pickMaster(M0_AWVALID, M1_AWVALID, wrLast_q);
                wrState_d = W_ADDR;
            end
            W_ADDR: if (S_AWVALID && S_AWREADY) wrState_d = W_DATA;
            W_DATA: if (S_WVALID && S_WREADY && S_WLAST) wrState_d = W_RESP;
            W_RESP: if (S_BVALID && S_BREADY) begin
                wrState_d = W_IDLE;
                wrLast_d  = wrSel_q;
            end
            default: wrState_d = W_IDLE;
        endcase
    end

    logic arPhase, rPhase, awPhase, wPhase, bPhase;
    assign arPhase = (rdState_q == R_ADDR);
    assign rPhase  = (rdState_q == R_DATA);
    assign awPhase = (wrState_q == W_ADDR);
    assign wPhase  = (wrState_q == W_DATA);
    assign bPhase  = (wrState_q == W_RESP);

    assign RD_GNT = (rdState_q == R_IDLE) ? 2'b00 : (rdSel_q ? 2'b10 : 2'b01);
    assign WR_GNT = (wrState_q == W_IDLE) ? 2'b00 : (wrSel_q ? 2'b10 : 2'b01);

    assign S_ARVALID  = arPhase & (rdSel_q ? M1_ARVALID : M0_ARVALID);
    assign S_ARID     = rdSel_q ? M1_ARID    : M0_ARID;
    assign S_ARADDR   = rdSel_q ? M1_ARADDR  : M0_ARADDR;
    assign S_ARLEN    = rdSel_q ? M1_ARLEN   : M0_ARLEN;
    assign S_ARSIZE   = rdSel_q ? M1_ARSIZE  : M0_ARSIZE;
    assign S_ARBURST  = rdSel_q ? M1_ARBURST : M0_ARBURST;
    assign M0_ARREADY = arPhase & ~rdSel_q & S_ARREADY;
    assign M1_ARREADY = arPhase &  rdSel_q & S_ARREADY;

    // Data/ID buses towards the idle master are forced to zero rather than left floating.
    assign S_RREADY  = rPhase & (rdSel_q ? M1_RREADY : M0_RREADY);
    assign M0_RVALID = rPhase & ~rdSel_q & S_RVALID;
    assign M1_RVALID = rPhase &  rdSel_q & S_RVALID;
    assign M0_RID    = (rPhase && !rdSel_q) ? S_RID   : '0;
    assign M0_RDATA  = (rPhase && !rdSel_q) ? S_RDATA : '0;
    assign M0_RRESP  = (rPhase && !rdSel_q) ? S_RRESP : '0;
    assign M0_RLAST  = rPhase & ~rdSel_q & S_RLAST;
    assign M1_RID    = (rPhase && rdSel_q) ? S_RID   : '0;
    assign M1_RDATA  = (rPhase && rdSel_q) ? S_RDATA : '0;
    assign M1_RRESP  = (rPhase && rdSel_q) ? S_RRESP : '0;
    assign M1_RLAST  = rPhase & rdSel_q & S_RLAST;

    assign S_AWVALID  = awPhase & (wrSel_q ? M1_AWVALID : M0_AWVALID);
    assign S_AWID     = wrSel_q ? M1_AWID    : M0_AWID;
    assign S_AWADDR   = wrSel_q ? M1_AWADDR  : M0_AWADDR;
    assign S_AWLEN    = wrSel_q ? M1_AWLEN   : M0_AWLEN;
    assign S_AWSIZE   = wrSel_q ? M1_AWSIZE  : M0_AWSIZE;
    assign S_AWBURST  = wrSel_q ? M1_AWBURST : M0_AWBURST;
    assign M0_AWREADY = awPhase & ~wrSel_q & S_AWREADY;
    assign M1_AWREADY = awPhase &  wrSel_q & S_AWREADY;

    // W is only opened after the AW handshake, so early W beats just wait at the master.
    assign S_WVALID  = wPhase & (wrSel_q ? M1_WVALID : M0_WVALID);
    assign S_WDATA   = wrSel_q ? M1_WDATA : M0_WDATA;
    assign S_WSTRB   = wrSel_q ? M1_WSTRB : M0_WSTRB;
    assign S_WLAST   = wPhase & (wrSel_q ? M1_WLAST : M0_WLAST);
    assign M0_WREADY = wPhase & ~wrSel_q & S_WREADY;
    assign M1_WREADY = wPhase &  wrSel_q & S_WREADY;

    assign S_BREADY  = bPhase & (wrSel_q ? M1_BREADY : M0_BREADY);
    assign M0_BVALID = bPhase & ~wrSel_q & S_BVALID;
    assign M1_BVALID = bPhase &  wrSel_q & S_BVALID;
    assign M0_BID    = (bPhase && !wrSel_q) ? S_BID   : '0;
    assign M0_BRESP  = (bPhase && !wrSel_q) ? S_BRESP : '0;
    assign M1_BID    = (bPhase && wrSel_q) ? S_BID   : '0;
    assign M1_BRESP  = (bPhase && wrSel_q) ? S_BRESP : '0;

endmodule

// File: doc/axi_mem_arb2.md
# axi_mem_arb2

Two-master AXI4 arbiter that shares the single 128-bit AXI4 memory slave (`axi_full_slv_sram`, DW=128, AW=14) between requester M0 (the `Rift2Chip` `memory_0` port) and requester M1 (a test-bench loader/DMA master). Read and write paths are arbitrated independently, each round-robin and transaction-locked. Each path has at most one outstanding transaction, so IDs pass through unmodified. The block sits between the chip's memory port and the SRAM slave in the simulation top.

## Interface
Parameters:
- `AW`, 32, address width on all AR/AW channels.
- `DW`, 128, data width; strobe width is DW/8.
- `IW`, 4, ID width.

Ports:
- `CLK`  in  1  single clock; all logic on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `M{0,1}_AR{VALID,READY,ID,ADDR,LEN,SIZE,BURST}`  in/out(READY)  1,1,IW,AW,8,3,2  master read-address channels.
- `M{0,1}_R{VALID,READY,ID,DATA,RESP,LAST}`  out/in(READY)  1,1,IW,DW,2,1  master read-data channels.
- `M{0,1}_AW{VALID,READY,ID,ADDR,LEN,SIZE,BURST}`  in/out(READY)  1,1,IW,AW,8,3,2  master write-address channels.
- `M{0,1}_W{VALID,READY,DATA,STRB,LAST}`  in/out(READY)  1,1,DW,DW/8,1  master write-data channels.
- `M{0,1}_B{VALID,READY,ID,RESP}`  out/in(READY)  1,1,IW,2  master write-response channels.
- `S_AR*`, `S_R*`, `S_AW*`, `S_W*`, `S_B*`  mirror of one master set with directions reversed; connects to the SRAM slave.
- `RD_GNT`  out  2  one-hot read grant (00 = idle).
- `WR_GNT`  out  2  one-hot write grant (00 = idle).

## Operation
- Read FSM states are `R_IDLE`, `R_ADDR`, `R_DATA`:
  - `R_IDLE`: if any `Mx_ARVALID`, latch the winner into `rd_sel` and go to `R_ADDR`.
  - `R_ADDR`: drive `S_AR* = M[rd_sel]_AR*`; `M[rd_sel]_ARREADY = S_ARREADY`; on the handshake go to `R_DATA`.
  - `R_DATA`: route `S_R*` to `M[rd_sel]`; `S_RREADY = M[rd_sel]_RREADY`; on `S_RVALID & S_RREADY & S_RLAST` go to `R_IDLE` and set `rd_last = rd_sel`.
- Write FSM states are `W_IDLE`, `W_ADDR`, `W_DATA`, `W_RESP`:
  - Selection in `W_IDLE` mirrors the read FSM.
  - `W_ADDR`: forward AW; on the handshake go to `W_DATA`.
  - `W_DATA`: forward W; on a handshake with `WLAST` go to `W_RESP`.
  - `W_RESP`: forward B; on the B handshake go to `W_IDLE` and set `wr_last`.
- W beats are never forwarded before the AW handshake, even if the master presents W first.
- Round-robin per path:
  - Only one master valid: that master wins.
  - Both valid: the master opposite to `rd_last`/`wr_last` wins.
  - `rd_last`/`wr_last` reset to 1, so M0 wins the first contention.
- Non-granted masters see all READY/VALID outputs at 0. Non-granted output data/ID buses are don't-care; drive them 0.
- In `R_IDLE`/`W_IDLE`, all `S_*VALID` and `S_*READY` outputs are 0.
- The grant is locked at selection. If a master drops VALID after being selected (a protocol violation), the FSM stays in its state.
- The read and write paths may be granted to different masters, or the same master, concurrently.

## Timing
- Reset (asynchronous): FSMs go to their IDLE states; `RD_GNT = WR_GNT = 00`; every VALID/READY output is 0; `rd_last = wr_last = 1`.
- Arbitration adds one cycle: `Mx_ARVALID` rising in cycle n gives `S_ARVALID = 1` in cycle n+1. AW behaves the same way.
- After the grant, all paths are combinational pass-through with zero added latency per beat, full throughput.
- Back-to-back transactions incur one idle cycle: the last beat or B handshake lands in cycle n, and the next `S_ARVALID`/`S_AWVALID` is asserted in cycle n+2.
- `RD_GNT`/`WR_GNT` are registered and valid from `R_ADDR`/`W_ADDR` through the end of the transaction.
- Reset asserted mid-burst aborts the transaction immediately. The slave is reset by the same event.

## Test plan
- Single M0 read, ARLEN=3, addr 0x8000_0000:
  - `S_ARVALID` one cycle after `M0_ARVALID`.
  - Four beats returned to M0 only, with `M1_RVALID = 0` throughout.
  - `RD_GNT` returns to 00 after `RLAST`.
- M0 and M1 both assert ARVALID in the same cycle after reset:
  - M0 is served first, then M1.
  - Repeat with both valid: grants alternate M0, M1, M0, M1.
- M1 write, AWLEN=1, STRB=16'hFFFF, data 0xA5…:
  - Two W beats reach the slave after the AW handshake.
  - `M1_BVALID` with `BRESP = 00`.
  - A later M0 read of the same address returns the data.
- M0 write concurrent with an M1 read: both proceed in parallel with `WR_GNT = 01` and `RD_GNT = 10`, and neither is delayed.
- W-before-AW: M0 presents WVALID two cycles before AWVALID; `S_WVALID` stays 0 until the AW handshake completes.
- `RST` pulsed during beat 2 of an ARLEN=7 read:
  - All outputs are 0 in the same cycle.
  - After release, a new M1 read completes normally.
